// File: rtl/add_sub_result_buffer.sv
`default_nettype none
// add_sub_result_buffer: FIFO of add/sub results with derived N/Z flags, valid/ready on both sides,
// and a sticky overflow status. Optional macro RESULT_SAT_EN saturates overflowed results. Rev 1.0
module add_sub_result_buffer #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_s,
  input  logic                     in_c,
  input  logic                     in_v,
  input  logic                     in_m,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_s,
  output logic [4:0]               out_flags,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     ovf_sticky,
  input  logic                     clr_sticky
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] C_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_s_mem    [DEPTH];
  logic [4:0]       r_flag_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             r_sticky;

  logic             w_push;
  logic             w_pop;
  logic [WIDTH-1:0] w_s_store;
  logic [4:0]       w_flags_store;

`ifdef RESULT_SAT_EN
  // Overflowed result clamps toward the sign the true result would have had.
  always_comb begin
    w_s_store = in_s;
    if (in_v)
      w_s_store = in_s[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}};
  end
`else
  assign w_s_store = in_s;
`endif

  assign w_flags_store = {in_m, w_s_store[WIDTH-1], (w_s_store == '0), in_c, in_v};

  assign in_ready  = (r_count != C_FULL);
  assign out_valid = (r_count != '0);
  assign w_push    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;

  assign out_s      = out_valid ? r_s_mem[r_rd_ptr]    : '0;
  assign out_flags  = out_valid ? r_flag_mem[r_rd_ptr] : '0;
  assign count      = r_count;
  assign ovf_sticky = r_sticky;

  // Storage needs no reset: contents are only visible while count marks them valid.
  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_s_mem[r_wr_ptr]    <= w_s_store;
      r_flag_mem[r_wr_ptr] <= w_flags_store;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_sticky <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_push && in_v)  r_sticky <= 1'b1;
      else if (clr_sticky) r_sticky <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_add_sub_result_buffer.sv
`default_nettype none
// tb_add_sub_result_buffer: directed scenarios plus randomized traffic against a queue-based model.
module tb_add_sub_result_buffer;
  localparam int W = 4;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [W-1:0] s;
    logic [4:0]   f;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_valid = 1'b0, in_c = 1'b0, in_v = 1'b0, in_m = 1'b0;
  logic out_ready = 1'b0, clr_sticky = 1'b0;
  logic [W-1:0] in_s = '0;
  logic in_ready, out_valid, ovf_sticky;
  logic [W-1:0] out_s;
  logic [4:0] out_flags;
  logic [2:0] count;

  int n_checks = 0;
  int n_pass = 0;
  ent_t mq[$];
  logic m_sticky = 1'b0;

  add_sub_result_buffer #(.WIDTH(W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_s(in_s), .in_c(in_c), .in_v(in_v), .in_m(in_m),
    .out_valid(out_valid), .out_ready(out_ready), .out_s(out_s),
    .out_flags(out_flags), .count(count), .ovf_sticky(ovf_sticky),
    .clr_sticky(clr_sticky)
  );

  always #5 clk = ~clk;

  function automatic ent_t make_entry(input logic [W-1:0] s, input logic c, input logic v,
                                      input logic m);
    ent_t e;
    int sv;
    sv = int'(s);
`ifdef RESULT_SAT_EN
    if (v) sv = (sv >= (1 << (W-1))) ? (1 << (W-1)) - 1 : (1 << (W-1));
`endif
    e.s = W'(sv);
    e.f = {m, (sv % (1 << W)) >= (1 << (W-1)), (sv % (1 << W)) == 0, c, v};
    return e;
  endfunction

  // One clock: drive inputs, let the edge happen, advance the model, settle 1 time unit.
  task automatic step(input logic iv, input logic [W-1:0] s, input logic c, input logic v,
                      input logic m, input logic ordy, input logic clr, input logic r);
    bit do_push, do_pop;
    in_valid = iv; in_s = s; in_c = c; in_v = v; in_m = m;
    out_ready = ordy; clr_sticky = clr; rst = r;
    @(posedge clk);
    if (r) begin
      mq.delete();
      m_sticky = 1'b0;
    end else begin
      do_push = iv && (mq.size() < DEPTH);
      do_pop  = (mq.size() > 0) && ordy;
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back(make_entry(s, c, v, m));
      if (do_push && v) m_sticky = 1'b1;
      else if (clr) m_sticky = 1'b0;
    end
    #1;
  endtask

  task automatic idle_reset();
    step(0, '0, 0, 0, 0, 0, 0, 1);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_reset();
    n_checks++;
    if ({in_ready, out_valid, count, ovf_sticky, out_s, out_flags} !== {1'b1, 1'b0, 3'd0, 1'b0, 4'd0, 5'd0})
      $display("FAIL reset: rdy=%b vld=%b cnt=%0d stk=%b s=%h f=%b, want 1 0 0 0 0 0",
               in_ready, out_valid, count, ovf_sticky, out_s, out_flags);
    else n_pass++;
  endtask

  task automatic test_overflow_push();
    logic [W-1:0] exp_s;
    logic [4:0] exp_f;
`ifdef RESULT_SAT_EN
    exp_s = 4'b0111; exp_f = 5'b00001;
`else
    exp_s = 4'b1000; exp_f = 5'b01001;
`endif
    idle_reset();
    step(1, 4'b1000, 0, 1, 0, 0, 0, 0);
    n_checks++;
    if ({out_valid, out_s, out_flags, ovf_sticky} !== {1'b1, exp_s, exp_f, 1'b1})
      $display("FAIL ovf_push: vld=%b s=%b f=%b stk=%b, want 1 %b %b 1",
               out_valid, out_s, out_flags, ovf_sticky, exp_s, exp_f);
    else n_pass++;
  endtask

  task automatic test_sub_order();
    idle_reset();
    step(1, 4'b0110, 1, 0, 1, 1, 0, 0);
    n_checks++;
    if ({out_s, out_flags, count} !== {4'b0110, 5'b10010, 3'd1})
      $display("FAIL sub_first: s=%b f=%b cnt=%0d, want 0110 10010 1", out_s, out_flags, count);
    else n_pass++;
    step(1, 4'b1110, 0, 0, 1, 1, 0, 0);
    n_checks++;
    if ({out_s, out_flags, count} !== {4'b1110, 5'b11000, 3'd1})
      $display("FAIL sub_second: s=%b f=%b cnt=%0d, want 1110 11000 1", out_s, out_flags, count);
    else n_pass++;
    step(0, '0, 0, 0, 0, 1, 0, 0);
    n_checks++;
    if ({out_valid, count, out_s, out_flags} !== {1'b0, 3'd0, 4'd0, 5'd0})
      $display("FAIL sub_drain: vld=%b cnt=%0d s=%b f=%b, want 0 0 0 0", out_valid, count, out_s, out_flags);
    else n_pass++;
  endtask

  task automatic test_full();
    idle_reset();
    for (int i = 1; i <= 4; i++) step(1, W'(i), 0, 0, 0, 0, 0, 0);
    n_checks++;
    if ({count, in_ready} !== {3'd4, 1'b0})
      $display("FAIL full_fill: cnt=%0d rdy=%b, want 4 0", count, in_ready);
    else n_pass++;
    step(1, 4'd5, 0, 0, 0, 0, 0, 0);
    n_checks++;
    if ({count, out_s} !== {3'd4, 4'd1})
      $display("FAIL full_hold: cnt=%0d head=%0d, want 4 1", count, out_s);
    else n_pass++;
    step(1, 4'd5, 0, 0, 0, 1, 0, 0);
    n_checks++;
    if ({count, out_s, in_ready} !== {3'd3, 4'd2, 1'b1})
      $display("FAIL full_popnopush: cnt=%0d head=%0d rdy=%b, want 3 2 1", count, out_s, in_ready);
    else n_pass++;
    step(1, 4'd5, 0, 0, 0, 0, 0, 0);
    n_checks++;
    if (count !== 3'd4) $display("FAIL full_resume: cnt=%0d, want 4", count);
    else n_pass++;
    for (int i = 2; i <= 5; i++) begin
      n_checks++;
      if (out_s !== W'(i)) $display("FAIL full_order%0d: head=%0d, want %0d", i, out_s, i);
      else n_pass++;
      step(0, '0, 0, 0, 0, 1, 0, 0);
    end
  endtask

  task automatic test_zero_wrap();
    idle_reset();
    step(1, 4'b0000, 1, 0, 1, 0, 0, 0);
    n_checks++;
    if ({out_s, out_flags} !== {4'b0000, 5'b10110})
      $display("FAIL zero_flag: s=%b f=%b, want 0000 10110", out_s, out_flags);
    else n_pass++;
    // Ten pushes with pops from the third cycle carry both pointers past the wrap point.
    for (int i = 0; i < 10; i++) begin
      step(1, W'(i + 3), 1'(i), 0, 0, (i >= 2), 0, 0);
      n_checks++;
      if ({out_valid, out_s, out_flags, count} !== {1'b1, mq[0].s, mq[0].f, 3'(mq.size())})
        $display("FAIL wrap%0d: vld=%b s=%0d f=%b cnt=%0d, want 1 %0d %b %0d",
                 i, out_valid, out_s, out_flags, count, mq[0].s, mq[0].f, mq.size());
      else n_pass++;
    end
  endtask

  task automatic test_reset_flush();
    idle_reset();
    for (int i = 0; i < 3; i++) step(1, W'(9 + i), 0, 1, 0, 0, 0, 0);
    step(1, 4'd7, 0, 1, 0, 1, 0, 1);
    rst = 1'b0;
    n_checks++;
    if ({count, out_valid, ovf_sticky, in_ready} !== {3'd0, 1'b0, 1'b0, 1'b1})
      $display("FAIL reset_flush: cnt=%0d vld=%b stk=%b rdy=%b, want 0 0 0 1",
               count, out_valid, ovf_sticky, in_ready);
    else n_pass++;
  endtask

  task automatic test_sticky();
    idle_reset();
    step(1, 4'b1000, 0, 1, 0, 0, 1, 0);
    n_checks++;
    if (ovf_sticky !== 1'b1) $display("FAIL sticky_setwins: stk=%b, want 1", ovf_sticky);
    else n_pass++;
    step(0, '0, 0, 0, 0, 0, 1, 0);
    n_checks++;
    if (ovf_sticky !== 1'b0) $display("FAIL sticky_clear: stk=%b, want 0", ovf_sticky);
    else n_pass++;
  endtask

  task automatic test_random();
    ent_t head;
    idle_reset();
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 99) < 60), W'($urandom), 1'($urandom), 1'($urandom_range(0, 9) < 2),
           1'($urandom), 1'($urandom_range(0, 99) < 45), 1'($urandom_range(0, 9) == 0),
           1'($urandom_range(0, 59) == 0));
      head = (mq.size() > 0) ? mq[0] : '0;
      n_checks++;
      if ({count, out_valid, in_ready, ovf_sticky} !==
          {3'(mq.size()), mq.size() > 0, mq.size() < DEPTH, m_sticky})
        $display("FAIL rnd_status%0d: cnt=%0d vld=%b rdy=%b stk=%b, want cnt=%0d stk=%b",
                 i, count, out_valid, in_ready, ovf_sticky, mq.size(), m_sticky);
      else n_pass++;
      n_checks++;
      if ({out_s, out_flags} !== {head.s, head.f})
        $display("FAIL rnd_head%0d: s=%b f=%b, want %b %b", i, out_s, out_flags, head.s, head.f);
      else n_pass++;
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_overflow_push();
    test_sub_order();
    test_full();
    test_zero_wrap();
    test_reset_flush();
    test_sticky();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
